// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI period scheduler: TMDS encoder modes,
// scheduler FSM states and the video-preamble/guard-band geometry.
package hdmi_pkg;

   typedef enum logic [1:0] {
      MODE_CTRL     = 2'd0,
      MODE_PREAMBLE = 2'd1,
      MODE_GUARD    = 2'd2,
      MODE_VIDEO    = 2'd3
   } tmds_mode_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } sched_state_t;

   localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;
   localparam int         PREAMBLE_LEN       = 8;
   localparam int         GUARD_LEN          = 2;

   // Inclusive range test on plain integers, so counter compares stay width-clean.
   function automatic logic in_range(input int val, input int lo, input int hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/hdmi_timing_counter.sv
// Horizontal/vertical raster counters with synchronous load, advance and
// end-of-line / end-of-frame flags.
module hdmi_timing_counter #(
   parameter int H_TOTAL = 800,
   parameter int V_TOTAL = 525,
   parameter int H_WIDTH = $clog2(H_TOTAL),
   parameter int V_WIDTH = $clog2(V_TOTAL)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               advance,
   input  logic [H_WIDTH-1:0] load_h,
   input  logic [V_WIDTH-1:0] load_v,
   output logic [H_WIDTH-1:0] h,
   output logic [V_WIDTH-1:0] v,
   output logic               line_end,
   output logic               frame_end
);

   assign line_end  = (h == H_WIDTH'(H_TOTAL - 1));
   assign frame_end = line_end && (v == V_WIDTH'(V_TOTAL - 1));

   // NOTE: state is updated with <= so every register samples pre-edge values;
   // blocking assignments here would make h/v order-dependent in simulation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h <= '0;
         v <= '0;
      end else if (load) begin
         h <= load_h;
         v <= load_v;
      end else if (advance) begin
         if (line_end) begin
            h <= '0;
            v <= frame_end ? '0 : v + V_WIDTH'(1);
         end else begin
            h <= h + H_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Video timing generator and TMDS period scheduler (control / preamble / guard / video).
// Build option: define HDMI_DVI_ONLY_EN for plain DVI output (no preamble, no guard band).
module hdmi_period_scheduler
   import hdmi_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   output logic                        hsync,
   output logic                        vsync,
   output logic                        de,
   output logic [1:0]                  mode,
   output logic [3:0]                  ctl,
   output logic [$clog2(H_ACTIVE)-1:0] x,
   output logic [$clog2(V_ACTIVE)-1:0] y,
   output logic                        frame_start,
   output logic                        busy
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int XW      = $clog2(H_ACTIVE);
   localparam int YW      = $clog2(V_ACTIVE);

   localparam int HS_START  = H_ACTIVE + H_FP;
   localparam int HS_END    = HS_START + H_SYNC - 1;
   localparam int VS_START  = V_ACTIVE + V_FP;
   localparam int VS_END    = VS_START + V_SYNC - 1;
   localparam int GB_START  = H_TOTAL - GUARD_LEN;
   localparam int PRE_START = GB_START - PREAMBLE_LEN;

`ifdef HDMI_DVI_ONLY_EN
   localparam bit DVI_ONLY = 1'b1;
   localparam int H_BP_MIN = 1;
`else
   localparam bit DVI_ONLY = 1'b0;
   localparam int H_BP_MIN = PREAMBLE_LEN + GUARD_LEN;
`endif

   // Preamble and guard band must fit entirely inside the horizontal back porch.
   if (H_BP < H_BP_MIN) begin : g_h_bp_too_small
      $error("hdmi_period_scheduler: H_BP=%0d is below the minimum of %0d", H_BP, H_BP_MIN);
   end

   sched_state_t  state;
   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          line_end;
   logic          frame_end;
   logic          cnt_load;
   logic          cnt_advance;

   assign cnt_load    = (state == IDLE) && enable;
   assign cnt_advance = (state != IDLE);

   // A start always enters at the top of vertical blanking so the sink sees a full blank first.
   hdmi_timing_counter #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL),
      .H_WIDTH (HW),
      .V_WIDTH (VW)
   ) u_counter (
      .clk       (clk),
      .reset     (reset),
      .load      (cnt_load),
      .advance   (cnt_advance),
      .load_h    (HW'(H_ACTIVE)),
      .load_v    (VW'(V_ACTIVE)),
      .h         (h),
      .v         (v),
      .line_end  (line_end),
      .frame_end (frame_end)
   );

   int         h_i;
   int         v_i;
   int         v_next;
   logic       active;
   logic       next_active;
   tmds_mode_t mode_d;
   logic [3:0] ctl_d;
   logic       hs_d;
   logic       vs_d;
   logic       fs_d;
   logic [XW-1:0] x_d;
   logic [YW-1:0] y_d;

   // NOTE: every signal gets a default at the top of always_comb so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      h_i         = int'(h);
      v_i         = int'(v);
      v_next      = (v_i == V_TOTAL - 1) ? 0 : v_i + 1;
      active      = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
      next_active = (v_next < V_ACTIVE);
      mode_d      = MODE_CTRL;
      ctl_d       = 4'b0000;

      if (active) begin
         mode_d = MODE_VIDEO;
      end else if (!DVI_ONLY && next_active && in_range(h_i, PRE_START, GB_START - 1)) begin
         mode_d = MODE_PREAMBLE;
         ctl_d  = CTL_VIDEO_PREAMBLE;
      end else if (!DVI_ONLY && next_active && in_range(h_i, GB_START, H_TOTAL - 1)) begin
         mode_d = MODE_GUARD;
      end

      hs_d = in_range(h_i, HS_START, HS_END) ? HS_POL : ~HS_POL;
      vs_d = in_range(v_i, VS_START, VS_END) ? VS_POL : ~VS_POL;
      fs_d = active && (h_i == 0) && (v_i == 0);
      x_d  = active ? h[XW-1:0] : '0;
      y_d  = active ? v[YW-1:0] : '0;
   end

   // FSM and output registers share one block; outputs reflect the counter
   // values held before each edge, so they trail the counters by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         mode        <= MODE_CTRL;
         ctl         <= 4'b0000;
         x           <= '0;
         y           <= '0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE:    if (enable) state <= RUN;
            RUN:     if (!enable) state <= DRAIN;
            DRAIN: begin
               if (enable)         state <= RUN;
               else if (frame_end) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (state == IDLE) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            mode        <= MODE_CTRL;
            ctl         <= 4'b0000;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
         end else begin
            hsync       <= hs_d;
            vsync       <= vs_d;
            de          <= active;
            mode        <= mode_d;
            ctl         <= ctl_d;
            x           <= x_d;
            y           <= y_d;
            frame_start <= fs_d;
            busy        <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler on a 34x8 raster (16x4 active);
// expectations adapt when HDMI_DVI_ONLY_EN is defined.
module tb_hdmi_period_scheduler;
   import hdmi_pkg::*;

   localparam int N = 400;

`ifdef HDMI_DVI_ONLY_EN
   localparam bit DVI = 1'b1;
`else
   localparam bit DVI = 1'b0;
`endif

   localparam logic [16:0] IDLE_VEC = 17'b0_0_1_1_0_00_0000_0000_00;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       hsync, vsync, de, frame_start, busy;
   logic [1:0] mode;
   logic [3:0] ctl;
   logic [3:0] x;
   logic [1:0] y;
   logic [16:0] obs;

   assign obs = {busy, frame_start, hsync, vsync, de, mode, ctl, x, y};

   always #5 clk = ~clk;

   hdmi_period_scheduler #(
      .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (12),
      .V_ACTIVE (4),  .V_FP (1), .V_SYNC (2), .V_BP (1),
      .HS_POL   (1'b0), .VS_POL (1'b0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .mode        (mode),
      .ctl         (ctl),
      .x           (x),
      .y           (y),
      .frame_start (frame_start),
      .busy        (busy)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Trace of outputs sampled at the falling edge after start edge k+n.
   logic       de_t   [1:N];
   logic       hs_t   [1:N];
   logic       vs_t   [1:N];
   logic       fs_t   [1:N];
   logic       busy_t [1:N];
   logic [1:0] m_t    [1:N];
   logic [3:0] c_t    [1:N];
   logic [3:0] x_t    [1:N];
   logic [1:0] y_t    [1:N];

   function automatic int cnt_mode(input int lo, input int hi, input logic [1:0] m);
      int c = 0;
      for (int i = lo; i <= hi; i++) if (m_t[i] == m) c++;
      return c;
   endfunction

   function automatic int cnt_low(input int lo, input int hi, input bit use_vs);
      int c = 0;
      for (int i = lo; i <= hi; i++) if ((use_vs ? vs_t[i] : hs_t[i]) == 1'b0) c++;
      return c;
   endfunction

   function automatic int first_low(input int lo, input int hi, input bit use_vs);
      for (int i = lo; i <= hi; i++) if ((use_vs ? vs_t[i] : hs_t[i]) == 1'b0) return i;
      return -1;
   endfunction

   task automatic start_latency(output int lat, output logic fs_at);
      lat   = -1;
      fs_at = 1'b0;
      @(negedge clk);
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (de) begin
            lat   = n;
            fs_at = frame_start;
            break;
         end
      end
   endtask

   initial begin
      int   first_de, cnt, de_cnt, busy_cnt, vs_cnt, lat;
      logic fs_at, found;

      reset  = 1'b1;
      enable = 1'b0;
      #2;
      check("reset_idle", obs, IDLE_VEC);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_hold", obs, IDLE_VEC);

      // First start: enable is sampled at edge k, the next rising edge.
      enable = 1'b1;
      @(negedge clk);
      check("start_edge_busy", busy, 1'b0);
      for (int n = 1; n <= N; n++) begin
         @(negedge clk);
         de_t[n] = de;  hs_t[n] = hsync; vs_t[n] = vsync; fs_t[n] = frame_start;
         busy_t[n] = busy; m_t[n] = mode; c_t[n] = ctl; x_t[n] = x; y_t[n] = y;
      end

      first_de = -1;
      for (int n = 1; n <= N; n++) if (de_t[n]) begin first_de = n; break; end
      check("first_de", first_de, 121);
      check("first_pixel", {fs_t[121], x_t[121], y_t[121]}, {1'b1, 4'd0, 2'd0});
      check("fs_one_cycle", {fs_t[122], x_t[122]}, {1'b0, 4'd1});
      check("line0_last_px", {de_t[136], x_t[136], de_t[137]}, {1'b1, 4'd15, 1'b0});
      check("line1_first_px", {de_t[155], x_t[155], y_t[155]}, {1'b1, 4'd0, 2'd1});
      cnt = 0;
      for (int n = 1; n <= N; n++) if (fs_t[n]) cnt++;
      check("fs_count", cnt, 2);
      cnt = 0;
      for (int n = 1; n <= N; n++) if (!busy_t[n]) cnt++;
      check("busy_run", cnt, 0);

      // Last blanking line (v=7) ahead of the first active line.
      check("pre_v7_before", m_t[110], MODE_CTRL);
      check("pre_v7_len", cnt_mode(111, 118, MODE_PREAMBLE), DVI ? 0 : 8);
      check("pre_v7_ctl", {c_t[111], c_t[118], c_t[119]}, DVI ? 12'h000 : 12'h110);
      check("guard_v7_len", cnt_mode(119, 120, MODE_GUARD), DVI ? 0 : 2);
      check("video_len", cnt_mode(121, 136, MODE_VIDEO), 16);
      // Back porch of active line 0 ahead of line 1.
      check("pre_line0", {m_t[144], m_t[145], m_t[152], m_t[153], m_t[154]},
            DVI ? 10'b00_00_00_00_00 : {MODE_CTRL, MODE_PREAMBLE, MODE_PREAMBLE, MODE_GUARD, MODE_GUARD});

      // Whole frame n=121..392.
      check("frame_pre", cnt_mode(121, 392, MODE_PREAMBLE), DVI ? 0 : 32);
      check("frame_guard", cnt_mode(121, 392, MODE_GUARD), DVI ? 0 : 8);
      check("frame_video", cnt_mode(121, 392, MODE_VIDEO), 64);
      cnt = 0;
      for (int n = 121; n <= 392; n++) if (c_t[n] != (m_t[n] == MODE_PREAMBLE ? 4'b0001 : 4'b0000)) cnt++;
      check("frame_ctl", cnt, 0);
      cnt = 0;
      for (int n = 121; n <= 392; n++) if (c_t[n] != 4'b0000) cnt++;
      check("frame_ctl_nz", cnt, DVI ? 0 : 32);

      check("hs_first", first_low(137, 170, 1'b0), 139);
      check("hs_width", cnt_low(137, 170, 1'b0), 4);
      check("vs_first", first_low(121, 392, 1'b1), 291);
      check("vs_width", cnt_low(121, 392, 1'b1), 68);
      check("vs_blank_frame", cnt_low(1, 120, 1'b1), 68);

      // Drop enable on the first pixel of line 2; the frame must finish.
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (de && y == 2'd2 && x == 4'd0) begin found = 1'b1; break; end
      end
      check("wait_line2", found, 1'b1);
      enable   = 1'b0;
      busy_cnt = 0;
      de_cnt   = 0;
      vs_cnt   = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy) break;
         busy_cnt++;
         if (de) de_cnt++;
         if (!vsync) vs_cnt++;
      end
      check("drain_busy", busy_cnt, 203);
      check("drain_de", de_cnt, 31);
      check("drain_vs", vs_cnt, 68);
      check("drain_idle", obs, IDLE_VEC);
      repeat (5) @(negedge clk);
      check("drain_idle_hold", obs, IDLE_VEC);

      // Second start, then asynchronous reset in the middle of video.
      enable = 1'b1;
      start_latency(lat, fs_at);
      check("start2_lat", lat, 121);
      check("start2_fs", fs_at, 1'b1);
      repeat (3) @(negedge clk);
      check("pre_arst_video", mode, MODE_VIDEO);
      #1;
      reset  = 1'b1;
      enable = 1'b0;
      #1;
      check("arst_idle", obs, IDLE_VEC);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("arst_release_idle", obs, IDLE_VEC);
      enable = 1'b1;
      start_latency(lat, fs_at);
      check("restart_lat", lat, 121);
      check("restart_fs", fs_at, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hdmi_period_scheduler.md
Name: hdmi_period_scheduler

Overview:
Video timing generator and TMDS period scheduler that sequences the HDMI_Encoder datapath. It runs the horizontal and vertical counters and produces hsync, vsync and DE. For every pixel clock it selects the TMDS encoder mode: control, video preamble, video guard band or active video. It also drives CTL[3:0]. It sits between the pixel source and the TMDS encoder/serializer, in the pixel clock domain.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels); elaboration error if < 10
V_ACTIVE, 480, active lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level

Ports:
clk  in  1  pixel clock
reset  in  1  async, active-high
enable  in  1  request to run; start and stop only at frame boundaries
hsync  out  1  horizontal sync at HS_POL
vsync  out  1  vertical sync at VS_POL
de  out  1  active-video enable
mode  out  2  tmds_mode_t: CTRL / PREAMBLE / GUARD / VIDEO
ctl  out  4  CTL3..CTL0 to the encoder control channels
x  out  $clog2(H_ACTIVE)  active pixel column; 0 when de=0
y  out  $clog2(V_ACTIVE)  active line; 0 when de=0
frame_start  out  1  one-cycle pulse with the first active pixel (x=0, y=0)
busy  out  1  high in RUN or DRAIN

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
- Internal counters: h counts 0..H_TOTAL-1, v counts 0..V_TOTAL-1; h=0 is the first active pixel. On h wrap, v increments and wraps at V_TOTAL-1.
- Region decode:
  - Active: h<H_ACTIVE and v<V_ACTIVE.
  - hsync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync asserted for whole lines v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- Next-line test: next line is active when (v+1) mod V_TOTAL < V_ACTIVE.
- Mode selection:
  - PREAMBLE for h in [H_TOTAL-10, H_TOTAL-3] when the next line is active; ctl=4'b0001 (CTL0=1).
  - GUARD for h in [H_TOTAL-2, H_TOTAL-1] when the next line is active; ctl=0.
  - VIDEO in the active region.
  - CTRL otherwise; ctl=0.
- Latency: all outputs are registered, one cycle behind the counters, and mutually aligned.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: counters held; if enable=1, load h=H_ACTIVE and v=V_ACTIVE and go to RUN. The frame always starts with a full vertical blanking.
  - RUN: counters advance every cycle. If enable=0, go to DRAIN.
  - DRAIN: counters keep advancing. At h=H_TOTAL-1, v=V_TOTAL-1 go to IDLE. A frame in progress is never truncated.
  - DRAIN with enable=1 again: return to RUN with no disturbance to the counters.
- IDLE outputs: mode=CTRL, de=0, ctl=0, hsync=!HS_POL, vsync=!VS_POL, x=y=0, frame_start=0, busy=0.
- Reset, including mid-frame: immediately forces IDLE and the IDLE output values above; the counters clear.
- Reset value of every output equals its IDLE value.

Optional Feature:
HDMI_DVI_ONLY_EN
- Defined: pure DVI output. No preamble or guard band; mode is only CTRL or VIDEO; ctl is tied to 0. The H_BP >= 10 check is relaxed to H_BP >= 1.
- Undefined: full HDMI video-period scheduling as described in Behaviour.

Decomposition:
- Package hdmi_pkg:
  - tmds_mode_t enum {MODE_CTRL=0, MODE_PREAMBLE=1, MODE_GUARD=2, MODE_VIDEO=3}
  - CTL_VIDEO_PREAMBLE = 4'b0001
  - PREAMBLE_LEN = 8, GUARD_LEN = 2
  - sched_state_t enum {IDLE, RUN, DRAIN}
- Sub-module hdmi_timing_counter: h/v counters with load, advance and wrap flags.
- The top level owns the FSM, region decode and output registers.

Test Plan:
Bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=4, H_BP=12 (H_TOTAL=34); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8).
- Start: reset released, enable sampled at edge k -> de=0 until after edge k+121; then de=1 with x=0, y=0 and frame_start=1 for one cycle.
- Line sequence before an active line -> mode=PREAMBLE with ctl=0001 for exactly 8 cycles, then GUARD for 2 cycles, then VIDEO for 16 cycles. On the last blanking line (v=7) the same 8/2 pattern occurs.
- Syncs -> hsync low for 4 cycles starting 2 cycles after de falls; vsync low for exactly 68 consecutive cycles per 272-cycle frame.
- enable dropped mid-frame (y=2) -> the frame completes all 4 active lines and the remaining blanking; busy falls after h=33, v=7; outputs then idle.
- Async reset pulse during VIDEO -> all outputs take reset values with no clock edge; a restart reproduces the start-scenario timing.
- HDMI_DVI_ONLY_EN defined -> mode never PREAMBLE or GUARD and ctl stays 0 across two frames; de timing is identical.
